// File: rtl/payload_char_feeder.sv
// rtl/payload_char_feeder.sv - 64-bit payload word to per-byte character-class feeder for the engine array
//
// Ports:
//   clk, rst              single clock, synchronous active-high reset
//   s_tdata/s_tkeep/      payload word stream; byte 0 (bits [7:0]) goes first,
//   s_tlast/s_tvalid/     keep is contiguous from bit 0 and only partial on the
//   s_tready              tlast word
//   cfg_we/cfg_addr/      class-table write port: cfg_data is the class
//   cfg_data              membership vector for byte value cfg_addr
//   char_match            class lines for the byte presented this cycle (0 when en=0)
//   en                    one payload byte presented this cycle
//   sod                   engine clear pulse, one cycle before a packet's first en
//   eod                   end-of-data strobe, one cycle after a packet's last en
//   pkt_len               packet byte count, updated with eod and held until the next one

module payload_char_feeder #(
    parameter int NUM_CLASSES = 40,
    parameter int LEN_WIDTH   = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [63:0]            s_tdata,
    input  logic [7:0]             s_tkeep,
    input  logic                   s_tlast,
    input  logic                   s_tvalid,
    output logic                   s_tready,
    input  logic                   cfg_we,
    input  logic [7:0]             cfg_addr,
    input  logic [NUM_CLASSES-1:0] cfg_data,
    output logic [NUM_CLASSES-1:0] char_match,
    output logic                   en,
    output logic                   sod,
    output logic                   eod,
    output logic [LEN_WIDTH-1:0]   pkt_len
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SOD,
        ST_BYTES,
        ST_WAIT,
        ST_EOD
    } state_t;

    state_t                 state;
    logic [63:0]            word_buf;
    logic [3:0]             keep_n;      // number of kept bytes in word_buf (0..8)
    logic                   last_q;      // word_buf is the tlast word
    logic [2:0]             idx;         // byte index within word_buf
    logic [LEN_WIDTH-1:0]   byte_cnt;

    // Not reset: the table is configuration and must survive a packet abort.
    logic [NUM_CLASSES-1:0] class_table [256];

    // Stage A (combinational from FSM state)
    logic                   a_en;
    logic                   a_sod;
    logic                   a_eod;
    logic [7:0]             a_byte;
    logic                   last_byte;
    logic                   accept;
    logic [3:0]             in_keep_n;
    logic [LEN_WIDTH-1:0]   cnt_inc;

    // keep is contiguous from bit 0, so its population count is the byte count.
    function automatic logic [3:0] keep_count(input logic [7:0] k);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, k[i]};
        end
        return n;
    endfunction

    always_comb begin
        a_en      = (state == ST_BYTES);
        a_sod     = (state == ST_SOD);
        a_eod     = (state == ST_EOD);
        a_byte    = word_buf[{idx, 3'b000} +: 8];
        last_byte = (state == ST_BYTES) && ({1'b0, idx} == (keep_n - 4'd1));
        // Ready is offered on the last byte of a non-final word so the next
        // word can follow without a bubble.
        s_tready  = !rst && ((state == ST_IDLE) || (state == ST_WAIT) ||
                             (last_byte && !last_q));
        accept    = s_tvalid && s_tready;
        in_keep_n = keep_count(s_tkeep);
        cnt_inc   = (&byte_cnt) ? byte_cnt : byte_cnt + 1'b1;
    end

    // Control FSM and word buffer
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            word_buf <= '0;
            keep_n   <= '0;
            last_q   <= 1'b0;
            idx      <= '0;
            byte_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        word_buf <= s_tdata;
                        keep_n   <= in_keep_n;
                        last_q   <= s_tlast;
                        byte_cnt <= '0;
                        state    <= ST_SOD;
                    end
                end
                ST_SOD: begin
                    idx   <= '0;
                    // An empty tlast word still produces sod/eod, just no bytes.
                    state <= (keep_n == 4'd0) ? ST_EOD : ST_BYTES;
                end
                ST_BYTES: begin
                    byte_cnt <= cnt_inc;
                    if (last_byte) begin
                        if (last_q) begin
                            state <= ST_EOD;
                        end else if (accept) begin
                            word_buf <= s_tdata;
                            keep_n   <= in_keep_n;
                            last_q   <= s_tlast;
                            idx      <= '0;
                            state    <= (in_keep_n == 4'd0) ? ST_EOD : ST_BYTES;
                        end else begin
                            state <= ST_WAIT;
                        end
                    end else begin
                        idx <= idx + 3'd1;
                    end
                end
                ST_WAIT: begin
                    if (accept) begin
                        word_buf <= s_tdata;
                        keep_n   <= in_keep_n;
                        last_q   <= s_tlast;
                        idx      <= '0;
                        state    <= (in_keep_n == 4'd0) ? ST_EOD : ST_BYTES;
                    end
                end
                ST_EOD: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Class table write port; a same-cycle read of the written address sees
    // the old contents because the read below samples before this update.
    always_ff @(posedge clk) begin
        if (cfg_we) begin
            class_table[cfg_addr] <= cfg_data;
        end
    end

    // Stage B: every output is registered here, aligned with the table read.
    always_ff @(posedge clk) begin
        if (rst) begin
            en         <= 1'b0;
            sod        <= 1'b0;
            eod        <= 1'b0;
            char_match <= '0;
            pkt_len    <= '0;
        end else begin
            en         <= a_en;
            sod        <= a_sod;
            eod        <= a_eod;
            char_match <= a_en ? class_table[a_byte] : '0;
            if (a_eod) begin
                pkt_len <= byte_cnt;
            end
        end
    end

endmodule

// File: tb/tb_payload_char_feeder.sv
// tb/tb_payload_char_feeder.sv - directed self-checking bench for payload_char_feeder

module tb_payload_char_feeder;

    localparam int NC = 40;
    localparam int LW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [63:0]   s_tdata = '0;
    logic [7:0]    s_tkeep = '0;
    logic          s_tlast = 1'b0;
    logic          s_tvalid = 1'b0;
    logic          s_tready;
    logic          cfg_we = 1'b0;
    logic [7:0]    cfg_addr = '0;
    logic [NC-1:0] cfg_data = '0;
    logic [NC-1:0] char_match;
    logic          en;
    logic          sod;
    logic          eod;
    logic [LW-1:0] pkt_len;

    payload_char_feeder #(.NUM_CLASSES(NC), .LEN_WIDTH(LW)) dut (
        .clk(clk), .rst(rst),
        .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tlast(s_tlast),
        .s_tvalid(s_tvalid), .s_tready(s_tready),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .char_match(char_match), .en(en), .sod(sod), .eod(eod), .pkt_len(pkt_len)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    int            en_cyc[$];
    logic [NC-1:0] en_cm[$];
    int            sod_cyc[$];
    int            eod_cyc[$];
    logic [LW-1:0] eod_len[$];
    int            rdy_cyc[$];
    int            viol = 0;

    // Event log sampled mid-cycle, well away from the active edge
    always @(negedge clk) begin
        #2;
        if (en) begin
            en_cyc.push_back(cyc);
            en_cm.push_back(char_match);
        end
        if (sod) sod_cyc.push_back(cyc);
        if (eod) begin
            eod_cyc.push_back(cyc);
            eod_len.push_back(pkt_len);
        end
        if (s_tready) rdy_cyc.push_back(cyc);
        if ((sod && en) || (sod && eod) || (!en && char_match != '0)) viol++;
    end

    function automatic logic [NC-1:0] f(input logic [7:0] b);
        return {8'hC3, 24'h0, b};
    endfunction

    function automatic int en_at(input int i);
        if (i >= 0 && i < en_cyc.size()) return en_cyc[i];
        return -1;
    endfunction
    function automatic logic [NC-1:0] cm_at(input int i);
        if (i >= 0 && i < en_cm.size()) return en_cm[i];
        return '1;
    endfunction
    function automatic int sod_at(input int i);
        if (i < sod_cyc.size()) return sod_cyc[i];
        return -1;
    endfunction
    function automatic int eod_at(input int i);
        if (i < eod_cyc.size()) return eod_cyc[i];
        return -1;
    endfunction
    function automatic logic [LW-1:0] len_at(input int i);
        if (i < eod_len.size()) return eod_len[i];
        return '1;
    endfunction

    task automatic clear_logs();
        en_cyc.delete(); en_cm.delete(); sod_cyc.delete();
        eod_cyc.delete(); eod_len.delete(); rdy_cyc.delete();
        viol = 0;
    endtask

    // Presents one word; holds valid low for the first 'gap' cycles in which
    // the DUT is ready. Returns the cycle at whose end the handshake occurs.
    task automatic send_word(input logic [63:0] d, input logic [7:0] k, input logic l,
                             input int gap, output int acc);
        int gl;
        int budget;
        bit done;
        gl = gap; budget = 0; done = 0; acc = -1;
        while (!done) begin
            @(negedge clk);
            s_tdata = d; s_tkeep = k; s_tlast = l;
            s_tvalid = (gl == 0);
            #1;
            if (s_tready) begin
                if (s_tvalid) begin
                    done = 1;
                    acc = cyc;
                end else begin
                    gl--;
                end
            end
            budget++;
            if (!done && budget > 200) begin
                n_checks++; n_fail++;
                $display("FAIL send_word_timeout: s_tready never accepted word %h", d);
                done = 1;
            end
        end
    endtask

    task automatic end_valid();
        @(negedge clk);
        s_tvalid = 1'b0;
    endtask

    task automatic wait_eod(input int n, input int budget);
        int b;
        b = 0;
        while (eod_cyc.size() < n && b < budget) begin
            @(negedge clk);
            b++;
        end
        repeat (2) @(negedge clk);
        n_checks++;
        if (eod_cyc.size() < n) begin
            n_fail++;
            $display("FAIL eod_timeout: got %0d eod pulses, need %0d", eod_cyc.size(), n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        for (int b = 0; b < 256; b++) begin
            @(negedge clk);
            cfg_we = 1'b1; cfg_addr = 8'(b); cfg_data = f(8'(b));
        end
        @(negedge clk); cfg_addr = 8'h47; cfg_data = 40'h1;
        @(negedge clk); cfg_addr = 8'h67; cfg_data = 40'h1;
        @(negedge clk); cfg_addr = 8'h20; cfg_data = 40'h100;
        @(negedge clk); cfg_we = 1'b0;
        #2;
        n_checks++; if (s_tready !== 1'b0) begin n_fail++; $display("FAIL reset_tready: got %b want 0", s_tready); end
        n_checks++; if ({en, sod, eod} !== 3'b000) begin n_fail++; $display("FAIL reset_strobes: got %b want 000", {en, sod, eod}); end
        n_checks++; if (char_match !== '0) begin n_fail++; $display("FAIL reset_char_match: got %h want 0", char_match); end
        n_checks++; if (pkt_len !== '0) begin n_fail++; $display("FAIL reset_pkt_len: got %h want 0", pkt_len); end
        @(negedge clk); rst = 1'b0;
        @(negedge clk); #2;
        n_checks++; if (s_tready !== 1'b1) begin n_fail++; $display("FAIL idle_tready: got %b want 1", s_tready); end
    endtask

    task automatic test_single_word();
        int acc;
        logic [NC-1:0] exp_cm [4];
        exp_cm = '{40'h001, 40'h100, 40'h100, 40'h001};
        clear_logs();
        send_word(64'h0000_0000_6720_2047, 8'h0F, 1'b1, 0, acc);
        end_valid();
        wait_eod(1, 40);
        n_checks++; if (sod_at(0) !== acc + 2) begin n_fail++; $display("FAIL t1_sod_cycle: got %0d want %0d", sod_at(0), acc + 2); end
        n_checks++; if (en_cyc.size() !== 4) begin n_fail++; $display("FAIL t1_en_count: got %0d want 4", en_cyc.size()); end
        n_checks++; if (en_at(0) !== acc + 3 || en_at(3) !== acc + 6) begin n_fail++; $display("FAIL t1_en_window: got %0d..%0d want %0d..%0d", en_at(0), en_at(3), acc + 3, acc + 6); end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (cm_at(i) !== exp_cm[i]) begin n_fail++; $display("FAIL t1_char_match[%0d]: got %h want %h", i, cm_at(i), exp_cm[i]); end
        end
        n_checks++; if (eod_at(0) !== acc + 7) begin n_fail++; $display("FAIL t1_eod_cycle: got %0d want %0d", eod_at(0), acc + 7); end
        n_checks++; if (len_at(0) !== 16'd4) begin n_fail++; $display("FAIL t1_pkt_len: got %0d want 4", len_at(0)); end
    endtask

    // Three-word packet, bytes 0x00..0x10; gap stalls the second word.
    task automatic run_three_words(input int gap, output int acc0);
        int acc1, acc2;
        clear_logs();
        send_word(64'h0706_0504_0302_0100, 8'hFF, 1'b0, 0, acc0);
        send_word(64'h0F0E_0D0C_0B0A_0908, 8'hFF, 1'b0, gap, acc1);
        send_word(64'hDEAD_BEEF_0000_0010, 8'h01, 1'b1, 0, acc2);
        end_valid();
        wait_eod(1, 60);
    endtask

    task automatic test_back_to_back_words();
        int acc;
        int nrdy;
        run_three_words(0, acc);
        n_checks++; if (en_cyc.size() !== 17) begin n_fail++; $display("FAIL t2_en_count: got %0d want 17", en_cyc.size()); end
        n_checks++; if (en_at(16) - en_at(0) !== 16) begin n_fail++; $display("FAIL t2_en_contiguous: span %0d want 16", en_at(16) - en_at(0)); end
        for (int i = 0; i < 17; i++) begin
            n_checks++;
            if (cm_at(i) !== f(8'(i))) begin n_fail++; $display("FAIL t2_byte[%0d]: got %h want %h", i, cm_at(i), f(8'(i))); end
        end
        nrdy = 0;
        foreach (rdy_cyc[i]) if (rdy_cyc[i] > acc && rdy_cyc[i] < eod_at(0)) nrdy++;
        n_checks++; if (nrdy !== 2) begin n_fail++; $display("FAIL t2_ready_count: got %0d want 2", nrdy); end
        n_checks++;
        if (!((acc + 9) inside {rdy_cyc}) || !((acc + 17) inside {rdy_cyc})) begin
            n_fail++; $display("FAIL t2_ready_cycles: ready missing at %0d or %0d", acc + 9, acc + 17);
        end
        n_checks++; if (len_at(0) !== 16'd17) begin n_fail++; $display("FAIL t2_pkt_len: got %0d want 17", len_at(0)); end
    endtask

    task automatic test_stall();
        int acc;
        run_three_words(3, acc);
        n_checks++; if (en_cyc.size() !== 17) begin n_fail++; $display("FAIL t3_en_count: got %0d want 17", en_cyc.size()); end
        n_checks++; if (en_at(7) !== acc + 10 || en_at(8) !== acc + 14) begin n_fail++; $display("FAIL t3_gap: en %0d then %0d want %0d then %0d", en_at(7), en_at(8), acc + 10, acc + 14); end
        n_checks++; if (en_at(16) - en_at(0) !== 19) begin n_fail++; $display("FAIL t3_span: got %0d want 19", en_at(16) - en_at(0)); end
        for (int i = 0; i < 17; i++) begin
            n_checks++;
            if (cm_at(i) !== f(8'(i))) begin n_fail++; $display("FAIL t3_byte[%0d]: got %h want %h", i, cm_at(i), f(8'(i))); end
        end
        n_checks++; if (eod_at(0) !== en_at(16) + 1) begin n_fail++; $display("FAIL t3_eod_after_last_en: got %0d want %0d", eod_at(0), en_at(16) + 1); end
        n_checks++; if (len_at(0) !== 16'd17) begin n_fail++; $display("FAIL t3_pkt_len: got %0d want 17", len_at(0)); end
    endtask

    task automatic test_empty_and_back_to_back();
        int acc, acc_a, acc_b;
        clear_logs();
        send_word(64'h0, 8'h00, 1'b1, 0, acc);
        end_valid();
        wait_eod(1, 20);
        n_checks++; if (sod_at(0) !== acc + 2) begin n_fail++; $display("FAIL t4_empty_sod: got %0d want %0d", sod_at(0), acc + 2); end
        n_checks++; if (eod_at(0) !== acc + 3) begin n_fail++; $display("FAIL t4_empty_eod: got %0d want %0d", eod_at(0), acc + 3); end
        n_checks++; if (en_cyc.size() !== 0) begin n_fail++; $display("FAIL t4_empty_en: got %0d en want 0", en_cyc.size()); end
        n_checks++; if (len_at(0) !== 16'd0) begin n_fail++; $display("FAIL t4_empty_len: got %0d want 0", len_at(0)); end

        clear_logs();
        send_word(64'h0000_0000_0000_0201, 8'h03, 1'b1, 0, acc_a);
        send_word(64'h0000_0000_0000_0005, 8'h01, 1'b1, 0, acc_b);
        end_valid();
        wait_eod(2, 40);
        n_checks++; if (len_at(0) !== 16'd2 || len_at(1) !== 16'd1) begin n_fail++; $display("FAIL t4_b2b_len: got %0d,%0d want 2,1", len_at(0), len_at(1)); end
        n_checks++; if (sod_at(1) !== acc_b + 2) begin n_fail++; $display("FAIL t4_b2b_sod: got %0d want %0d", sod_at(1), acc_b + 2); end
        n_checks++; if (!(sod_at(1) > eod_at(0))) begin n_fail++; $display("FAIL t4_b2b_order: sod %0d not after eod %0d", sod_at(1), eod_at(0)); end
        n_checks++; if (viol !== 0) begin n_fail++; $display("FAIL t4_overlap: got %0d violations want 0", viol); end
    endtask

    task automatic test_reset_mid_packet();
        int acc, acc2;
        clear_logs();
        send_word(64'h3736_3534_3332_3130, 8'hFF, 1'b1, 0, acc);
        end_valid();
        while (cyc < acc + 7) @(negedge clk);
        rst = 1'b1;
        #3;
        n_checks++; if (s_tready !== 1'b0) begin n_fail++; $display("FAIL t5_tready_in_rst: got %b want 0", s_tready); end
        n_checks++; if (en_cyc.size() !== 5) begin n_fail++; $display("FAIL t5_bytes_before_rst: got %0d want 5", en_cyc.size()); end
        @(negedge clk); rst = 1'b0;
        #3;
        n_checks++;
        if ({en, sod, eod} !== 3'b000 || char_match !== '0 || pkt_len !== '0) begin
            n_fail++; $display("FAIL t5_outputs_after_rst: en/sod/eod %b cm %h len %0d want all 0", {en, sod, eod}, char_match, pkt_len);
        end
        repeat (20) @(negedge clk);
        n_checks++; if (eod_cyc.size() !== 0) begin n_fail++; $display("FAIL t5_no_eod: got %0d eod want 0", eod_cyc.size()); end
        clear_logs();
        send_word(64'h0000_0000_0052_5150, 8'h07, 1'b1, 0, acc2);
        end_valid();
        wait_eod(1, 30);
        n_checks++; if (sod_at(0) !== acc2 + 2) begin n_fail++; $display("FAIL t5_new_sod: got %0d want %0d", sod_at(0), acc2 + 2); end
        n_checks++; if (len_at(0) !== 16'd3) begin n_fail++; $display("FAIL t5_new_len: got %0d want 3", len_at(0)); end
    endtask

    task automatic test_cfg_collision();
        int acc;
        logic [NC-1:0] nv;
        nv = 40'h5A_0000_1234;
        clear_logs();
        send_word(64'h0000_0000_0041_0041, 8'h07, 1'b1, 0, acc);
        end_valid();
        @(negedge clk);
        cfg_we = 1'b1; cfg_addr = 8'h41; cfg_data = nv;
        @(negedge clk);
        cfg_we = 1'b0;
        wait_eod(1, 30);
        n_checks++; if (cm_at(0) !== f(8'h41)) begin n_fail++; $display("FAIL t6_old_value: got %h want %h", cm_at(0), f(8'h41)); end
        n_checks++; if (cm_at(1) !== f(8'h00)) begin n_fail++; $display("FAIL t6_mid_byte: got %h want %h", cm_at(1), f(8'h00)); end
        n_checks++; if (cm_at(2) !== nv) begin n_fail++; $display("FAIL t6_new_value: got %h want %h", cm_at(2), nv); end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_back_to_back_words();
        test_stall();
        test_empty_and_back_to_back();
        test_reset_mid_packet();
        test_cfg_collision();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/payload_char_feeder.md
Name: payload_char_feeder

Overview:
- Front end of the payload engine array: accepts packet payload as a 64-bit word stream and serialises it to one byte per cycle.
- Decodes each byte through a programmable 256-entry character-class table into NUM_CLASSES one-hot-per-class match lines. These lines drive the in_N inputs of every engine_*.
- Generates the engines' shared per-byte enable (en), the start-of-data clear pulse (sod) and an end-of-data strobe (eod), so a collector can sample the engine outputs.

Parameters:
- NUM_CLASSES, 40, number of character-class match lines (bit k drives in_k of all engines).
- LEN_WIDTH, 16, width of the payload byte counter reported at eod.

Ports:
- clk  input  1  single clock.
- rst  input  1  synchronous, active-high reset.
- s_tdata  input  64  payload word; byte 0 = bits[7:0] is first on the wire.
- s_tkeep  input  8  byte valid mask; contiguous from bit 0; all-ones except on the tlast word.
- s_tlast  input  1  last word of packet.
- s_tvalid  input  1  word valid.
- s_tready  output  1  word accepted when s_tvalid && s_tready.
- cfg_we  input  1  class-table write strobe.
- cfg_addr  input  8  byte value to configure.
- cfg_data  input  NUM_CLASSES  class membership bits for cfg_addr.
- char_match  output  NUM_CLASSES  class lines for the current byte; valid when en=1, else 0.
- en  output  1  one payload byte presented this cycle.
- sod  output  1  one-cycle engine clear pulse before a packet's first byte.
- eod  output  1  one-cycle pulse one cycle after the packet's last en.
- pkt_len  output  LEN_WIDTH  byte count of the packet; valid with eod.

Behaviour:
- Reset:
  - All outputs 0, s_tready 0 during rst; FSM goes to IDLE; word buffer and byte counter cleared.
  - The class table is NOT cleared by rst; it powers up all-zero.
- Reset mid-packet: the in-flight packet is discarded with no eod. The first word accepted after reset starts a new packet.
- Two-stage datapath:
  - Stage A (FSM + byte mux) produces byte/en/sod/eod.
  - Stage B registers them together with the registered table read.
  - All outputs are stage-B registers.
- FSM states:
  - IDLE: s_tready=1. On accept, load the buffer, capture keep/last, clear the counter, go to SOD.
  - SOD: stage-A sod=1, en=0, s_tready=0; next state BYTES with byte index 0.
  - BYTES:
    - Emit buffer byte[idx] with en=1 each cycle; increment the counter (saturating at all-ones).
    - On the last kept byte of a non-tlast word: s_tready=1 that cycle.
    - If a word is accepted, reload the buffer and continue at idx 0 next cycle with no bubble.
    - If no word is available, stay in BYTES-WAIT (en=0, s_tready=1) until accept.
    - On the last kept byte of the tlast word: go to EOD.
  - EOD: stage-A eod=1, s_tready=0; pkt_len takes the final count; next state IDLE.
- tlast word with s_tkeep=0:
  - Accepted in BYTES-WAIT: BYTES-WAIT goes straight to EOD, no extra en.
  - Accepted in IDLE: SOD, then EOD with pkt_len=0.
- Latency:
  - Word accepted in IDLE at cycle T → sod=1 at T+2 → first en at T+3.
  - eod is high exactly one cycle after the last en; consecutive packets are separated by at least 2 idle cycles (EOD, IDLE).
- Table:
  - Synchronous write on cfg_we.
  - Read is registered in stage B.
  - A write to the address being read in the same cycle returns the old data.
  - Writes are legal at any time and affect subsequent lookups only.
- sod and en are never high in the same cycle. char_match is forced to 0 when en=0.
- pkt_len holds its value until the next eod.

Test Plan:
- Table maps 'G'(0x47) and 'g'(0x67) → bit0, 0x20 → bit8. Packet word 0x0000_0000_6720_2047, tkeep=0x0F, tlast. Required: sod at T+2; en on T+3..T+6; char_match = 0x001, 0x100, 0x100, 0x001; eod at T+7; pkt_len=4.
- 3-word packet, upstream valid every cycle, last tkeep=0x01. Required: 17 consecutive en cycles with no gap; s_tready high only on byte 7 of words 1 and 2; pkt_len=17.
- Same packet with s_tvalid dropped for 3 cycles before word 2. Required: en low for exactly those wait cycles, byte order preserved, pkt_len=17.
- Empty tlast word (tkeep=0) in IDLE. Required: sod pulse, no en, eod with pkt_len=0. Two back-to-back packets: sod never coincides with en or the previous eod.
- rst asserted at byte 5 of a packet. Required: next cycle all outputs 0, no eod. The following packet starts with sod at acceptance+2 and pkt_len counts only its own bytes.
- cfg write to 0x41 in the same cycle 0x41 is looked up. Required: old class value output for that byte; the next 0x41 shows the new value.
